crc_checker: RTL

//  Receive-side counterpart of the CRC generator on the memory access path.

---
 rtl/crc_checker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/crc_checker.sv
// crc_checker
//   Receive-side CRC check on the memory read path. A {data, crc} codeword is
//   accepted, re-divided bit-serially (MSB first) by the generator polynomial
//   and the data word, final remainder and error flag are presented on a
//   valid/ready output. A saturating counter tracks the number of failed checks.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   poly                generator polynomial (MSB implied 1, ignored)
//   cw_valid/cw_ready   input handshake, cw_in = {data, crc}
//   out_valid/out_ready output handshake
//   data_out, rem_out   data field and remainder of the checked codeword
//   crc_err             remainder is non-zero
//   err_cnt             saturating count of failed checks since reset
module crc_checker #(
   parameter int DATA_W = 4,
   parameter int CRC_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CRC_W:0]          poly,
   input  logic                    cw_valid,
   output logic                    cw_ready,
   input  logic [DATA_W+CRC_W-1:0] cw_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       data_out,
   output logic [CRC_W-1:0]        rem_out,
   output logic                    crc_err,
   output logic [CNT_W-1:0]        err_cnt
);

   localparam int CW_W = DATA_W + CRC_W;
   localparam int BC_W = $clog2(CW_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CW_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW_W-1:0]   cw_q, cw_d;
   logic [CRC_W-1:0]  poly_q, poly_d;
   logic [CRC_W-1:0]  rem_q, rem_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [CRC_W-1:0]  rem_out_q, rem_out_d;
   logic              crc_err_q, crc_err_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic              fb;
   logic [CRC_W-1:0]  rem_step;

   always_comb begin
      state_d    = state_q;
      cw_d       = cw_q;
      poly_d     = poly_q;
      rem_d      = rem_q;
      bit_cnt_d  = bit_cnt_q;
      data_out_d = data_out_q;
      rem_out_d  = rem_out_q;
      crc_err_d  = crc_err_q;
      err_cnt_d  = err_cnt_q;

      // One division step on the current MSB of the codeword register
      fb       = rem_q[CRC_W-1];
      rem_step = {rem_q[CRC_W-2:0], cw_q[CW_W-1]} ^ (fb ? poly_q : '0);

      unique case (state_q)
         S_IDLE: begin
            if (cw_valid) begin
               cw_d      = cw_in;
               poly_d    = poly[CRC_W-1:0];
               rem_d     = '0;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Rotate rather than shift: after CW_W steps the register holds
            // the original codeword again, so the data field is still there
            // when the result is latched.
            cw_d      = {cw_q[CW_W-2:0], cw_q[CW_W-1]};
            rem_d     = rem_step;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               data_out_d = cw_d[CW_W-1:CRC_W];
               rem_out_d  = rem_step;
               crc_err_d  = |rem_step;
               if (crc_err_d && (err_cnt_q != '1))
                  err_cnt_d = err_cnt_q + 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cw_q       <= '0;
         poly_q     <= '0;
         rem_q      <= '0;
         bit_cnt_q  <= '0;
         data_out_q <= '0;
         rem_out_q  <= '0;
         crc_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cw_q       <= cw_d;
         poly_q     <= poly_d;
         rem_q      <= rem_d;
         bit_cnt_q  <= bit_cnt_d;
         data_out_q <= data_out_d;
         rem_out_q  <= rem_out_d;
         crc_err_q  <= crc_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign cw_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign data_out  = data_out_q;
   assign rem_out   = rem_out_q;
   assign crc_err   = crc_err_q;
   assign err_cnt   = err_cnt_q;

endmodule
